// File: rtl/btn_step_ctrl.sv
// Converts a debounced button level into single-step pulses plus a wrapping step counter.
// Latency: step_pulse 1 cycle after the first sampled press, step_cnt updates 1 cycle later.
// No backpressure: pulses are fire-and-forget; optional auto-repeat built with BTN_STEP_REPEAT_EN.
module btn_step_ctrl #(
  parameter int CNT_W         = 4,
  parameter int CNT_MAX       = 15,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 20000000
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
  input  logic             btn_lvl,
  input  logic             btn_clr,
  output logic             step_pulse,
  output logic [CNT_W-1:0] step_cnt,
  output logic             wrap,
  output logic [1:0]       state_o
);

  // Encodings are visible on state_o, so they are fixed explicitly.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_PRESS  = 2'b01,
    ST_REPEAT = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

  // Elaboration-time sanity checks on the configuration.
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("btn_step_ctrl: CNT_W must be at least 1");
  end
  if (CNT_MAX < 0 || CNT_MAX > (2 ** CNT_W) - 1) begin : g_bad_cnt_max
    $error("btn_step_ctrl: CNT_MAX does not fit in CNT_W bits");
  end
  // A one-cycle hold or repeat period would put two pulses back to back.
  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_timing
    $error("btn_step_ctrl: HOLD_CYCLES and REPEAT_CYCLES must be at least 2");
  end

  state_e           state_q;
  logic             step_pulse_q;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic             wrap_q, wrap_d;
  logic             btn_q, clr_q;
  logic             armed_q;
  logic             rise, crise;

`ifdef BTN_STEP_REPEAT_EN
  localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

  logic [TMR_W-1:0] timer_q;
  logic [TMR_W-1:0] timer_inc;

  // Saturating increment: the terminal compares reset the timer long before
  // it fills, so this only guards against a silent wrap.
  always_comb begin
    timer_inc = timer_q;
    if (timer_q != {TMR_W{1'b1}}) begin
      timer_inc = timer_q + TMR_W'(1);
    end
  end
`endif

  // Edge registers sample the levels every cycle; armed_q masks the first
  // edge after reset so a button already held through reset is not a press.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      btn_q   <= 1'b0;
      clr_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      btn_q   <= btn_lvl;
      clr_q   <= btn_clr;
      armed_q <= 1'b1;
    end
  end

  assign rise  = btn_lvl & ~btn_q & armed_q;
  assign crise = btn_clr & ~clr_q;

  // Press/repeat FSM with a registered one-cycle step pulse.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      step_pulse_q <= 1'b0;
`ifdef BTN_STEP_REPEAT_EN
      timer_q      <= '0;
`endif
    end else begin
      step_pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_q      <= ST_PRESS;
            step_pulse_q <= 1'b1;
`ifdef BTN_STEP_REPEAT_EN
            timer_q      <= '0;
`endif
          end
        end
        ST_PRESS: begin
          if (!btn_lvl) begin
            state_q <= ST_IDLE;
          end
`ifdef BTN_STEP_REPEAT_EN
          else if (timer_q == HOLD_LAST) begin
            state_q      <= ST_REPEAT;
            step_pulse_q <= 1'b1;
            timer_q      <= '0;
          end else begin
            timer_q <= timer_inc;
          end
`endif
        end
`ifdef BTN_STEP_REPEAT_EN
        ST_REPEAT: begin
          if (!btn_lvl) begin
            state_q <= ST_IDLE;
          end else if (timer_q == REP_LAST) begin
            step_pulse_q <= 1'b1;
            timer_q      <= '0;
          end else begin
            timer_q <= timer_inc;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Counter next state: a clear rise wins over a coincident step, which is dropped.
  always_comb begin
    step_cnt_d = step_cnt_q;
    wrap_d     = 1'b0;
    if (crise) begin
      step_cnt_d = '0;
    end else if (step_pulse_q) begin
      if (step_cnt_q == CNT_LAST) begin
        step_cnt_d = '0;
        wrap_d     = 1'b1;
      end else begin
        step_cnt_d = step_cnt_q + CNT_W'(1);
      end
    end
  end

  // Step counter and wrap flag registers.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      step_cnt_q <= step_cnt_d;
      wrap_q     <= wrap_d;
    end
  end

  assign step_pulse = step_pulse_q;
  assign step_cnt   = step_cnt_q;
  assign wrap       = wrap_q;
  assign state_o    = state_q;

  // Structural invariants of the pulse and counter paths.
  a_no_adjacent_pulse: assert property (@(posedge clk_100MHz) disable iff (!rst_n)
    step_pulse_q |=> !step_pulse_q);

  a_wrap_lands_on_zero: assert property (@(posedge clk_100MHz) disable iff (!rst_n)
    wrap_q |-> (step_cnt_q == '0));

`ifdef BTN_STEP_REPEAT_EN
  a_state_legal: assert property (@(posedge clk_100MHz) disable iff (!rst_n)
    state_q != 2'b11);
`else
  a_no_repeat_state: assert property (@(posedge clk_100MHz) disable iff (!rst_n)
    (state_q == ST_IDLE) || (state_q == ST_PRESS));
`endif

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Bench for btn_step_ctrl: directed scenarios plus randomized button/clear/reset traffic.
// Expected outputs come from a hold-duration model of the press rules.
// Works with BTN_STEP_REPEAT_EN defined or undefined.
module tb_btn_step_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 5;
  localparam int HOLD    = 8;
  localparam int REP     = 4;
`ifdef BTN_STEP_REPEAT_EN
  localparam int REP_EN  = 1;
`else
  localparam int REP_EN  = 0;
`endif

  logic             clk_100MHz = 1'b0;
  logic             rst_n      = 1'b0;
  logic             btn_lvl    = 1'b0;
  logic             btn_clr    = 1'b0;
  logic             step_pulse;
  logic [CNT_W-1:0] step_cnt;
  logic             wrap;
  logic [1:0]       state_o;

  btn_step_ctrl #(
    .CNT_W        (CNT_W),
    .CNT_MAX      (CNT_MAX),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .rst_n     (rst_n),
    .btn_lvl   (btn_lvl),
    .btn_clr   (btn_clr),
    .step_pulse(step_pulse),
    .step_cnt  (step_cnt),
    .wrap      (wrap),
    .state_o   (state_o)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state: whether a press is active and how many edges
  // it has been held for, plus the expected registered outputs.
  int m_prev_btn = 0;
  int m_prev_clr = 0;
  int m_first    = 1;
  int m_active   = 0;
  int m_n        = 0;
  int m_pulse    = 0;
  int m_cnt      = 0;
  int m_wrap     = 0;
  int m_state    = 0;

  int obs_pulses = 0;
  int obs_wraps  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the current input levels.
  task automatic model_edge();
    int rise;
    int crise;
    if (!rst_n) begin
      m_prev_btn = 0; m_prev_clr = 0; m_first = 1;
      m_active = 0; m_n = 0; m_pulse = 0;
      m_cnt = 0; m_wrap = 0; m_state = 0;
      return;
    end
    rise  = (btn_lvl && !m_prev_btn && !m_first) ? 1 : 0;
    crise = (btn_clr && !m_prev_clr) ? 1 : 0;
    // Counter reacts to the pulse that was visible before this edge.
    if (crise != 0) begin
      m_cnt  = 0;
      m_wrap = 0;
    end else if (m_pulse != 0) begin
      m_wrap = (m_cnt == CNT_MAX) ? 1 : 0;
      m_cnt  = (m_cnt + 1) % (CNT_MAX + 1);
    end else begin
      m_wrap = 0;
    end
    // Pulse on the press edge, then (repeat build) at HOLD edges into the
    // hold and every REP edges after that.
    if (m_active != 0) begin
      if (!btn_lvl) begin
        m_active = 0;
        m_pulse  = 0;
      end else begin
        m_n++;
        m_pulse = (REP_EN != 0 && m_n >= HOLD && ((m_n - HOLD) % REP) == 0) ? 1 : 0;
      end
    end else begin
      m_pulse = rise;
      if (rise != 0) begin
        m_active = 1;
        m_n      = 0;
      end
    end
    m_state    = (m_active == 0) ? 0 : ((REP_EN != 0 && m_n >= HOLD) ? 2 : 1);
    m_prev_btn = btn_lvl ? 1 : 0;
    m_prev_clr = btn_clr ? 1 : 0;
    m_first    = 0;
  endtask

  // One clock: model the edge, then compare all outputs shortly after it.
  task automatic tick();
    @(posedge clk_100MHz);
    model_edge();
    #1;
    check_eq("pulse", 32'(step_pulse), m_pulse);
    check_eq("cnt",   32'(step_cnt),   m_cnt);
    check_eq("wrap",  32'(wrap),       m_wrap);
    check_eq("state", 32'(state_o),    m_state);
    if (step_pulse) obs_pulses++;
    if (wrap) obs_wraps++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic tap();
    btn_lvl = 1'b1;
    tick();
    btn_lvl = 1'b0;
    ticks(2);
  endtask

  task automatic clear_cnt();
    btn_clr = 1'b1;
    tick();
    btn_clr = 1'b0;
    tick();
  endtask

  initial begin
    int len;

    // Reset
    rst_n = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    tick();
    check_eq("rst_pulse", 32'(step_pulse), 0);
    check_eq("rst_cnt",   32'(step_cnt),   0);
    check_eq("rst_wrap",  32'(wrap),       0);
    check_eq("rst_state", 32'(state_o),    0);

    // Single tap, level held three cycles
    obs_pulses = 0;
    btn_lvl = 1'b1;
    tick();
    check_eq("tap_latency", 32'(step_pulse), 1);
    ticks(2);
    btn_lvl = 1'b0;
    ticks(2);
    check_eq("tap_pulses", obs_pulses, 1);
    check_eq("tap_cnt", 32'(step_cnt), 1);
    check_eq("tap_idle", 32'(state_o), 0);

    // Long hold, long enough for six steps with auto-repeat
    clear_cnt();
    obs_pulses = 0;
    obs_wraps  = 0;
    btn_lvl = 1'b1;
    ticks(28);
    btn_lvl = 1'b0;
    ticks(2);
    check_eq("hold_pulses", obs_pulses, (REP_EN != 0) ? 6 : 1);
    check_eq("hold_cnt", 32'(step_cnt), (REP_EN != 0) ? 0 : 1);
    check_eq("hold_wraps", obs_wraps, (REP_EN != 0) ? 1 : 0);
    check_eq("hold_idle", 32'(state_o), 0);

    // Wrap through six taps
    clear_cnt();
    obs_wraps = 0;
    for (int i = 0; i < 6; i++) begin
      tap();
      check_eq("wrap_seq_cnt", 32'(step_cnt), (i + 1) % 6);
    end
    check_eq("wrap_once", obs_wraps, 1);

    // Clear rise coincident with a step pulse
    clear_cnt();
    for (int i = 0; i < 3; i++) tap();
    check_eq("sim_pre_cnt", 32'(step_cnt), 3);
    btn_lvl = 1'b1;
    tick();
    check_eq("sim_pulse", 32'(step_pulse), 1);
    btn_clr = 1'b1;
    tick();
    check_eq("sim_cnt", 32'(step_cnt), 0);
    check_eq("sim_wrap", 32'(wrap), 0);
    btn_lvl = 1'b0;
    btn_clr = 1'b0;
    ticks(2);
    check_eq("sim_post_cnt", 32'(step_cnt), 0);

    // Reset in the middle of a hold
    btn_lvl = 1'b1;
    ticks(12);
    check_eq("midhold_state", 32'(state_o), (REP_EN != 0) ? 2 : 1);
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    obs_pulses = 0;
    ticks(20);
    check_eq("midhold_no_pulse", obs_pulses, 0);
    check_eq("midhold_idle", 32'(state_o), 0);
    btn_lvl = 1'b0;
    tick();
    btn_lvl = 1'b1;
    tick();
    check_eq("midhold_fresh_press", 32'(step_pulse), 1);
    btn_lvl = 1'b0;
    ticks(2);

    // Randomized segments of button levels with sporadic clears and resets
    for (int k = 0; k < 150; k++) begin
      btn_lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 20));
      for (int j = 0; j < len; j++) begin
        btn_clr = ($urandom_range(0, 7) == 0);
        rst_n   = !($urandom_range(0, 199) == 0);
        tick();
      end
    end
    rst_n   = 1'b1;
    btn_lvl = 1'b0;
    btn_clr = 1'b0;
    ticks(3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
